imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the decode-stage immediate extender. It supports XLEN=32 or 64 and adds U-type, CSR-zimm and shift-amount formats. Each decoded instruction carries a sideband tag and passes through a valid/ready register stage with a 2-entry skid buffer, which decouples decode from the register-read/execute stage without losing throughput. It also flags and counts illegal immediate selectors, and supports pipeline flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 only (elaboration error otherwise)
TAG_W, 8, width of the sideband tag carried alongside each immediate (rd/ROB index)
CNT_W, 16, width of the saturating illegal-selector counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all buffered entries
in_valid  input  1  upstream has an instruction
in_ready  output  1  block can accept this cycle
instr  input  32  full instruction word; bits [6:0] are ignored
imm_src  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z, 110 SH, 111 reserved
in_tag  input  TAG_W  sideband tag
out_valid  output  1  output entry valid
out_ready  input  1  downstream accepts
imm_ext  output  XLEN  extended immediate
out_tag  output  TAG_W  tag matching imm_ext
out_err  output  1  entry was produced from reserved imm_src
err_cnt  output  CNT_W  saturating count of accepted reserved selectors

Behaviour:
- Formats (sign bit is instr[31] unless stated; all results extend to XLEN):
  - I: {sext, instr[31:20]}
  - S: {sext, instr[31:25], instr[11:7]}
  - B: {sext, instr[7], instr[30:25], instr[11:8], 0}
  - J: {sext, instr[19:12], instr[20], instr[30:21], 0}
  - U: {instr[31:12], 12'b0}; for XLEN=64, bits [63:32] are copies of instr[31]
  - Z: zero-extend instr[19:15]
  - SH: zero-extend instr[25:20] for XLEN=64; zero-extend instr[24:20] for XLEN=32
  - 111: imm_ext=0, out_err=1
- The extension logic is purely combinational on the input side. The result is registered on acceptance.
- Latency: 1 cycle from an accepted input (in_valid & in_ready) to out_valid, when the output is empty or draining.
- Storage: output register (entry 0) plus one skid entry (entry 1). Entry 0 is always the oldest.
  - in_ready = !skid_full. It is registered-derived, so there is no combinational path from out_ready.
  - Output fire (out_valid & out_ready): entry 1 moves to entry 0 if valid; otherwise the accepted input fills entry 0.
  - Input accepted while entry 0 is valid and not firing: the input goes to the skid entry.
  - Simultaneous fire and accept with the skid full cannot occur, because in_ready is 0.
  - Full throughput: 1 transfer/cycle when out_ready is held high.
- Output stability: while out_valid=1 and out_ready=0, imm_ext, out_tag and out_err hold stable.
- flush (synchronous, highest priority):
  - Both entries are invalidated at the next edge and out_valid=0.
  - An input offered in the flush cycle is dropped and not counted.
  - in_ready=1 on the cycle after a flush.
- err_cnt: increments on accepted inputs with imm_src=111 and saturates at 2^CNT_W-1 (no wrap). flush does not clear it; only reset does.
- Reset (async assert, sync deassert handled externally):
  - out_valid=0, skid empty, in_ready=1
  - imm_ext=0, out_tag=0, out_err=0, err_cnt=0
- Reset mid-transfer discards all entries. No output fires during reset.

Decomposition:
- Shared package (imm_pkg):
  - imm_src localparams IMM_I..IMM_RSV (3-bit)
  - XLEN legality check
  - entry struct {imm, tag, err}
- Sub-module imm_ext_core: the combinational format mux (instr, imm_src -> imm, err), parametrised by XLEN. The top level holds the skid/handshake and the counter.

Test Plan:
- XLEN=32, I, instr=0xFFF00093 -> imm_ext=0xFFFFFFFF one cycle after accept. XLEN=64 gives 0xFFFFFFFFFFFFFFFF.
- B instr=0xFE000EE3 -> 0xFFFFFFFC. J instr=0x0080006F -> 0x00000008. U instr=0x80000037 at XLEN=64 -> 0xFFFFFFFF80000000.
- Z instr rs1 field=0x1F -> 0x1F. SH instr[25:20]=0x3F -> 0x3F at XLEN=64 and 0x1F at XLEN=32.
- Backpressure: out_ready=0, present tags 1,2,3 back-to-back. Tags 1 and 2 are accepted; in_ready=0 before tag 3 is taken. Raising out_ready outputs 1, 2, 3 in order with no loss or duplication.
- flush asserted with both entries full and in_valid=1 -> out_valid=0 next cycle, in_ready=1, and the input is not delivered.
- imm_src=111 repeated 2^CNT_W+2 times (CNT_W=4) -> out_err=1 and imm_ext=0 each time; err_cnt saturates at 15. Async reset mid-stream returns all outputs to reset values immediately.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate extender: selector encodings
// and the datapath-width legality rule.
package imm_pkg;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_J   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_Z   = 3'b101;
  localparam logic [2:0] IMM_SH  = 3'b110;
  localparam logic [2:0] IMM_RSV = 3'b111;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate format mux: decodes instr/imm_src into an
// XLEN-wide immediate and flags the reserved selector.
module imm_ext_core
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  // Opcode bits play no part in any immediate format.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm = '0;
    err = 1'b0;
    case (imm_src)
      IMM_I:   imm = XLEN'($signed(instr[31:20]));
      IMM_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_J:   imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_U:   imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_Z:   imm = XLEN'(instr[19:15]);
      IMM_SH:  imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate extender with a valid/ready output register, a
// one-entry skid buffer, flush, and a saturating reserved-selector counter.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  entry_t           e0_q, e0_d, e1_q, e1_d, in_e;
  logic             v0_q, v0_d, v1_q, v1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  core_imm;
  logic             core_err;
  logic             accept, fire;

  imm_ext_core #(.XLEN(XLEN)) u_core (
    .instr   (instr),
    .imm_src (imm_src),
    .imm     (core_imm),
    .err     (core_err)
  );

  assign in_e      = '{imm: core_imm, tag: in_tag, err: core_err};
  assign in_ready  = ~v1_q;
  assign accept    = in_valid & ~v1_q & ~flush;
  assign fire      = v0_q & out_ready;
  assign out_valid = v0_q;
  assign imm_ext   = e0_q.imm;
  assign out_tag   = e0_q.tag;
  assign out_err   = e0_q.err;
  assign err_cnt   = cnt_q;

  // Entry 0 is always the oldest; the skid entry only fills while entry 0
  // stalls, and it cannot coexist with an accept because in_ready drops.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    v0_d  = v0_q;
    v1_d  = v1_q;
    cnt_d = cnt_q;
    if (flush) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else begin
      if (fire) begin
        if (v1_q) begin
          e0_d = e1_q;
          v1_d = 1'b0;
        end else if (accept) begin
          e0_d = in_e;
        end else begin
          v0_d = 1'b0;
        end
      end else if (accept) begin
        if (v0_q) begin
          e1_d = in_e;
          v1_d = 1'b1;
        end else begin
          e0_d = in_e;
          v0_d = 1'b1;
        end
      end
      if (accept && core_err && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      v0_q  <= v0_d;
      v1_q  <= v1_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 (CNT_W=4) and XLEN=64 instances share
// stimulus and are checked against a queue-based reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic [7:0]  in_tag;

  logic        rdy32, vld32, err32, rdy64, vld64, err64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [7:0]  tag32, tag64;
  logic [3:0]  cnt32;
  logic [15:0] cnt64;

  int unsigned total = 0;
  int unsigned passed = 0;

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  src;
    logic [7:0]  tag;
  } item_t;

  item_t       q[$];
  int unsigned mcnt32 = 0;
  int unsigned mcnt64 = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(vld32),
    .out_ready(out_ready), .imm_ext(imm32), .out_tag(tag32), .out_err(err32),
    .err_cnt(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(vld64),
    .out_ready(out_ready), .imm_ext(imm64), .out_tag(tag64), .out_err(err64),
    .err_cnt(cnt64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic longint sx(input longint f, input int bits);
    return (f >= (longint'(1) << (bits - 1))) ? f - (longint'(1) << bits) : f;
  endfunction

  // Immediate value computed arithmetically from field positions.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] s, input int xl);
    longint x, v;
    x = longint'(w);
    case (s)
      3'd0: v = sx(x >> 20, 12);
      3'd1: v = sx((x >> 25) * 32 + ((x >> 7) & 31), 12);
      3'd2: v = sx(((x >> 31) & 1) * 4096 + ((x >> 7) & 1) * 2048 +
                   ((x >> 25) & 63) * 32 + ((x >> 8) & 15) * 2, 13);
      3'd3: v = sx(((x >> 31) & 1) * (longint'(1) << 20) + ((x >> 12) & 255) * 4096 +
                   ((x >> 20) & 1) * 2048 + ((x >> 21) & 1023) * 2, 21);
      3'd4: v = sx(x & 64'hFFFF_F000, 32);
      3'd5: v = (x >> 15) & 31;
      3'd6: v = (x >> 20) & ((xl == 64) ? 63 : 31);
      default: v = 0;
    endcase
    if (xl == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic check_state();
    chk("out_valid32", 64'(vld32), 64'(q.size() > 0));
    chk("out_valid64", 64'(vld64), 64'(q.size() > 0));
    chk("in_ready32", 64'(rdy32), 64'(q.size() < 2));
    chk("in_ready64", 64'(rdy64), 64'(q.size() < 2));
    chk("err_cnt32", 64'(cnt32), 64'(mcnt32));
    chk("err_cnt64", 64'(cnt64), 64'(mcnt64));
    if (q.size() > 0) begin
      chk("imm32", 64'(imm32), ref_imm(q[0].ins, q[0].src, 32));
      chk("imm64", imm64, ref_imm(q[0].ins, q[0].src, 64));
      chk("tag32", 64'(tag32), 64'(q[0].tag));
      chk("tag64", 64'(tag64), 64'(q[0].tag));
      chk("err32", 64'(err32), 64'(q[0].src == 3'd7));
      chk("err64", 64'(err64), 64'(q[0].src == 3'd7));
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic cycle(input bit iv, input logic [31:0] ins, input logic [2:0] src,
                       input logic [7:0] tg, input bit ordy, input bit fl);
    bit fire, acc;
    in_valid = iv; instr = ins; imm_src = src; in_tag = tg; out_ready = ordy; flush = fl;
    fire = (q.size() > 0) && ordy;
    acc  = iv && (q.size() < 2) && !fl;
    if (fl) q.delete();
    else begin
      if (fire) void'(q.pop_front());
      if (acc) q.push_back('{ins: ins, src: src, tag: tg});
    end
    if (acc && src == 3'd7) begin
      if (mcnt32 < 15) mcnt32++;
      if (mcnt64 < 65535) mcnt64++;
    end
    @(posedge clk); #1;
    check_state();
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  src;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
    vecs[1] = '{32'h7FF00013, 3'd0, 32'h000007FF, 64'h00000000_000007FF, 1'b0};
    vecs[2] = '{32'hFE000FA3, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
    vecs[3] = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
    vecs[4] = '{32'h0080006F, 3'd3, 32'h00000008, 64'h00000000_00000008, 1'b0};
    vecs[5] = '{32'h80000037, 3'd4, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0};
    vecs[6] = '{32'h000F8073, 3'd5, 32'h0000001F, 64'h00000000_0000001F, 1'b0};
    vecs[7] = '{32'h03F00013, 3'd6, 32'h0000001F, 64'h00000000_0000003F, 1'b0};
    vecs[8] = '{32'h12345678, 3'd7, 32'h00000000, 64'h00000000_00000000, 1'b1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; imm_src = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check_state();
    chk("rst_imm64", imm64, 64'h0);
    chk("rst_tag32", 64'(tag32), 64'h0);
    chk("rst_err32", 64'(err32), 64'h0);
    rst_n = 1'b1;

    // Format table, one instruction per cycle with the output always ready.
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, vecs[i].ins, vecs[i].src, 8'(i + 1), 1'b1, 1'b0);
      chk("tbl_imm32", 64'(imm32), 64'(vecs[i].e32));
      chk("tbl_imm64", imm64, vecs[i].e64);
      chk("tbl_err", 64'(err32), 64'(vecs[i].err));
      chk("tbl_valid", 64'(vld64), 64'h1);
    end
    cycle(1'b0, '0, 3'd0, 8'd0, 1'b1, 1'b0);

    // Backpressure: tags 1 and 2 accepted, tag 3 held off until space frees.
    cycle(1'b1, 32'h00100013, 3'd0, 8'd1, 1'b0, 1'b0);
    chk("bp_tag1", 64'(tag32), 64'd1);
    cycle(1'b1, 32'h00200013, 3'd0, 8'd2, 1'b0, 1'b0);
    chk("bp_full_ready", 64'(rdy32), 64'h0);
    chk("bp_hold_tag1", 64'(tag64), 64'd1);
    cycle(1'b1, 32'h00300013, 3'd0, 8'd3, 1'b0, 1'b0);
    chk("bp_stable_imm", 64'(imm32), 64'd1);
    cycle(1'b1, 32'h00300013, 3'd0, 8'd3, 1'b1, 1'b0);
    chk("bp_tag2", 64'(tag32), 64'd2);
    cycle(1'b1, 32'h00300013, 3'd0, 8'd3, 1'b1, 1'b0);
    chk("bp_tag3", 64'(tag32), 64'd3);
    cycle(1'b0, '0, 3'd0, 8'd0, 1'b1, 1'b0);
    chk("bp_drained", 64'(vld32), 64'h0);

    // Flush with both entries full and an input offered.
    cycle(1'b1, 32'h00A00013, 3'd0, 8'd10, 1'b0, 1'b0);
    cycle(1'b1, 32'h00B00013, 3'd0, 8'd11, 1'b0, 1'b0);
    cycle(1'b1, 32'h00C00013, 3'd7, 8'd12, 1'b0, 1'b1);
    chk("fl_valid", 64'(vld32), 64'h0);
    chk("fl_ready", 64'(rdy64), 64'h1);
    cycle(1'b0, '0, 3'd0, 8'd0, 1'b1, 1'b0);
    chk("fl_no_deliver", 64'(vld64), 64'h0);
    // Flush with space available: the offered reserved input is neither stored nor counted.
    cycle(1'b1, 32'h00D00013, 3'd0, 8'd13, 1'b0, 1'b0);
    cycle(1'b1, 32'h00E00013, 3'd7, 8'd14, 1'b0, 1'b1);
    chk("fl_drop_valid", 64'(vld32), 64'h0);

    // Reserved selector repeated past the 4-bit counter range.
    for (int i = 0; i < 18; i++) begin
      cycle(1'b1, $urandom, 3'd7, 8'(i), 1'b1, 1'b0);
      chk("rsv_err", 64'(err32), 64'h1);
      chk("rsv_imm", imm64, 64'h0);
    end
    chk("sat_cnt32", 64'(cnt32), 64'd15);
    cycle(1'b0, '0, 3'd0, 8'd0, 1'b1, 1'b0);

    // Randomised traffic with backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, $urandom, 3'($urandom % 8), 8'($urandom),
            ($urandom % 3) != 0, ($urandom % 25) == 0);
    end

    // Asynchronous reset in the middle of a stalled stream.
    cycle(1'b1, 32'hFFF00093, 3'd0, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 32'h80000037, 3'd4, 8'hBB, 1'b0, 1'b0);
    chk("ar_pre_valid", 64'(vld32), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(vld32), 64'h0);
    chk("ar_ready", 64'(rdy64), 64'h1);
    chk("ar_imm64", imm64, 64'h0);
    chk("ar_tag", 64'(tag64), 64'h0);
    chk("ar_err", 64'(err64), 64'h0);
    chk("ar_cnt32", 64'(cnt32), 64'h0);
    chk("ar_cnt64", 64'(cnt64), 64'h0);
    @(posedge clk); #1;
    chk("ar_hold_valid", 64'(vld64), 64'h0);
    q.delete(); mcnt32 = 0; mcnt64 = 0;
    rst_n = 1'b1;
    cycle(1'b1, 32'h0080006F, 3'd3, 8'h01, 1'b1, 1'b0);
    chk("ar_after_imm", 64'(imm32), 64'h8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
